// File: rtl/watch_ctrl.sv
// watch_ctrl: conditions the start/stop and clear buttons, runs the IDLE/RUN/PAUSE
// state machine and produces the 0.01 s tick and the clear pulse for the digit chain.
// Optional lap/freeze support is compiled in when WATCH_LAP_EN is defined.
module watch_ctrl #(
  parameter int unsigned DIV        = 100000,
  parameter int unsigned DEB_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_ss,
  input  logic btn_clr,
`ifdef WATCH_LAP_EN
  input  logic btn_lap,
  output logic freeze,
`endif
  output logic tick,
  output logic clear,
  output logic running,
  output logic paused
);

  // Button lanes: 0 = start/stop, 1 = clear, 2 = lap (when present).
`ifdef WATCH_LAP_EN
  localparam int unsigned NumBtn = 3;
`else
  localparam int unsigned NumBtn = 2;
`endif
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned PW = $clog2(DIV);
  localparam logic [DW-1:0] DebLast = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PreLast = PW'(DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_t;

  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] sync1;
  logic [NumBtn-1:0] sync2;
  logic [NumBtn-1:0] db;
  logic [NumBtn-1:0] db_q;
  logic [NumBtn-1:0] press;
  logic [DW-1:0]     dcnt [NumBtn];

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_d;
  logic          clear_d;
  logic          ss_press;
  logic          clr_press;
`ifdef WATCH_LAP_EN
  logic          freeze_d;
  logic          lap_press;
`endif

`ifdef WATCH_LAP_EN
  assign btn_raw = {btn_lap, btn_clr, btn_ss};
`else
  assign btn_raw = {btn_clr, btn_ss};
`endif

  // Synchronise raw buttons, then accept a new level only after DEB_CYCLES stable samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < int'(NumBtn); i++) begin
        dcnt[i] <= '0;
      end
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < int'(NumBtn); i++) begin
        if (sync2[i] == db[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DebLast) begin
          db[i]   <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  // One-cycle press on each debounced rising edge; releases are ignored.
  assign press     = db & ~db_q;
  assign ss_press  = press[0];
  assign clr_press = press[1];
`ifdef WATCH_LAP_EN
  assign lap_press = press[2];
`endif

  // Next state, prescaler and the pulses to be registered this edge.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    clear_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ss_press) begin
          state_d = StRun;
          presc_d = '0;
        end else if (clr_press) begin
          clear_d = 1'b1;
        end
      end
      StRun: begin
        // Pausing on the wrap edge suppresses both the wrap and the tick.
        if (ss_press) begin
          state_d = StPause;
        end else if (presc_q == PreLast) begin
          presc_d = '0;
          tick_d  = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      StPause: begin
        // Clear wins over start/stop when both arrive together.
        if (clr_press) begin
          state_d = StIdle;
          presc_d = '0;
          clear_d = 1'b1;
        end else if (ss_press) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StIdle;
        presc_d = '0;
      end
    endcase
  end

`ifdef WATCH_LAP_EN
  // Lap toggles freeze only while running; any return to IDLE drops it.
  always_comb begin
    freeze_d = freeze;
    if ((state_q == StRun) && lap_press) begin
      freeze_d = ~freeze;
    end
    if (state_d == StIdle) begin
      freeze_d = 1'b0;
    end
  end
`endif

  // State, prescaler and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      presc_q <= '0;
      tick    <= 1'b0;
      clear   <= 1'b0;
      running <= 1'b0;
      paused  <= 1'b0;
`ifdef WATCH_LAP_EN
      freeze  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick    <= tick_d;
      clear   <= clear_d;
      running <= (state_d == StRun);
      paused  <= (state_d == StPause);
`ifdef WATCH_LAP_EN
      freeze  <= freeze_d;
`endif
    end
  end

endmodule

// File: tb/tb_watch_ctrl.sv
// tb_watch_ctrl: directed timing checks plus randomized button traffic, compared every
// cycle against a behavioural model of the watch control rules. Lap checks need WATCH_LAP_EN.
module tb_watch_ctrl;

  localparam int unsigned DIV = 4;
  localparam int unsigned DEB = 3;
`ifdef WATCH_LAP_EN
  localparam bit LapEn = 1'b1;
`else
  localparam bit LapEn = 1'b0;
`endif
  localparam int BSs  = 0;
  localparam int BClr = 1;
  localparam int BLap = 2;
  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MPause = 2;

  logic clk = 1'b0;
  logic rst;
  logic btn_ss;
  logic btn_clr;
  logic btn_lap;
  logic tick;
  logic clear;
  logic running;
  logic paused;
  logic dut_frz;

  int n_chk  = 0;
  int n_pass = 0;
  int edge_no;

  always #5 clk = ~clk;

  watch_ctrl #(
    .DIV        (DIV),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_ss  (btn_ss),
    .btn_clr (btn_clr),
`ifdef WATCH_LAP_EN
    .btn_lap (btn_lap),
    .freeze  (dut_frz),
`endif
    .tick    (tick),
    .clear   (clear),
    .running (running),
    .paused  (paused)
  );

`ifndef WATCH_LAP_EN
  assign dut_frz = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit         m_valid = 1'b0;
  int         m_state;
  int         m_cnt;          // counting edges spent in RUN since leaving IDLE
  logic [2:0] m_db, m_dbq;
  logic [2:0] m_dl[$];        // raw samples still inside the two-stage synchroniser
  logic [2:0] m_hist[$];      // last DEB synchronised samples
  bit         e_tick, e_clear, e_frz;

  always @(posedge clk) begin : model
    logic [2:0] raw, s2, prs;
    bit flip;
    raw = {(LapEn ? btn_lap : 1'b0), btn_clr, btn_ss};
    if (rst) begin
      m_valid = 1'b1;
      m_state = MIdle;
      m_cnt   = 0;
      m_db    = '0;
      m_dbq   = '0;
      m_dl    = {3'b000, 3'b000};
      m_hist  = {};
      e_tick  = 1'b0;
      e_clear = 1'b0;
      e_frz   = 1'b0;
    end else if (m_valid) begin
      prs     = m_db & ~m_dbq;
      e_tick  = 1'b0;
      e_clear = 1'b0;
      case (m_state)
        MIdle: begin
          if (prs[BSs]) begin m_state = MRun; m_cnt = 0; end
          else if (prs[BClr]) e_clear = 1'b1;
        end
        MRun: begin
          if (LapEn && prs[BLap]) e_frz = !e_frz;
          if (prs[BSs]) m_state = MPause;
          else begin
            m_cnt++;
            if (m_cnt % DIV == 0) e_tick = 1'b1;
          end
        end
        default: begin
          if (prs[BClr]) begin m_state = MIdle; m_cnt = 0; e_clear = 1'b1; e_frz = 1'b0; end
          else if (prs[BSs]) m_state = MRun;
        end
      endcase
      // A debounced level flips once DEB consecutive synchronised samples disagree with it.
      s2 = m_dl.pop_front();
      m_dl.push_back(raw);
      m_hist.push_back(s2);
      if (m_hist.size() > int'(DEB)) void'(m_hist.pop_front());
      m_dbq = m_db;
      for (int b = 0; b < 3; b++) begin
        if (m_hist.size() == int'(DEB)) begin
          flip = 1'b1;
          foreach (m_hist[j]) if (m_hist[j][b] == m_db[b]) flip = 1'b0;
          if (flip) m_db[b] = ~m_db[b];
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cycle_outputs", {27'd0, tick, clear, running, paused, dut_frz},
            {27'd0, e_tick, e_clear, m_state == MRun, m_state == MPause, e_frz});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step_to(input int e);
    while (edge_no < e) begin
      @(negedge clk);
      edge_no++;
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      BSs:     btn_ss  = v;
      BClr:    btn_clr = v;
      default: btn_lap = v;
    endcase
  endtask

  task automatic press_btn(input int b);
    set_btn(b, 1'b1);
    repeat (4) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; btn_ss = 1'b1; btn_clr = 1'b0; btn_lap = 1'b0;
    // Reset held for two edges with start/stop pressed.
    repeat (2) @(negedge clk);
    check("reset_outputs", {27'd0, tick, clear, running, paused, dut_frz}, 32'd0);
    rst = 1'b0;
    edge_no = 0;
    step_to(5);  check("run_not_before_edge6", running, 0);
    step_to(6);  check("run_at_edge6", running, 1);
    step_to(8);  btn_ss = 1'b0;
    step_to(9);  check("tick_not_early", tick, 0);
    step_to(10); check("first_tick_div_after", tick, 1);
    step_to(11); check("tick_one_cycle", tick, 0);
    step_to(14); check("tick_spacing", tick, 1);
    step_to(15); btn_ss = 1'b1;
    step_to(19); btn_ss = 1'b0;
    step_to(20); check("still_running", {paused, running}, 2'b01);
    step_to(21); check("paused_presc2", {paused, running}, 2'b10);
    step_to(22); check("no_tick_in_pause", tick, 0);
    step_to(25); btn_ss = 1'b1;
    step_to(29); btn_ss = 1'b0;
    step_to(30); check("held_pause", paused, 1);
    step_to(31); check("resumed", running, 1);
    step_to(32); check("resume_no_early_tick", tick, 0);
    step_to(33); check("resume_tick_after_2", tick, 1);
    step_to(35); btn_ss = 1'b1;
    step_to(39); btn_ss = 1'b0;
    step_to(41); check("pause_at_wrap_no_tick", {tick, paused}, 2'b01);
    // Simultaneous presses in PAUSE: clear wins.
    step_to(45); btn_ss = 1'b1; btn_clr = 1'b1;
    step_to(49); btn_ss = 1'b0; btn_clr = 1'b0;
    step_to(50); check("pre_clear", clear, 0);
    step_to(51); check("both_in_pause", {clear, running, paused}, 3'b100);
    step_to(52); check("clear_one_cycle", clear, 0);
    step_to(55); btn_ss = 1'b1;
    step_to(59); btn_ss = 1'b0;
    step_to(61); check("restart", running, 1);
    // Simultaneous presses in RUN: pause only.
    step_to(65); btn_ss = 1'b1; btn_clr = 1'b1;
    step_to(69); btn_ss = 1'b0; btn_clr = 1'b0;
    step_to(71); check("both_in_run", {clear, running, paused}, 3'b001);
    step_to(72); check("no_clear_from_run", clear, 0);
    // Two-cycle glitches on both buttons.
    step_to(75); btn_ss = 1'b1; btn_clr = 1'b1;
    step_to(77); btn_ss = 1'b0; btn_clr = 1'b0;
    step_to(90); check("glitch_ignored", {clear, running, paused}, 3'b001);
    press_btn(BClr);
    check("clr_to_idle", {running, paused}, 2'b00);
    if (LapEn) begin
      press_btn(BLap); check("lap_idle_ignored", dut_frz, 0);
      press_btn(BSs);  check("lap_run", running, 1);
      press_btn(BLap); check("lap_freeze_on", dut_frz, 1);
      press_btn(BLap); check("lap_freeze_off", dut_frz, 0);
      press_btn(BLap); check("lap_freeze_on2", dut_frz, 1);
      press_btn(BSs);  check("lap_pause_keeps", {paused, dut_frz}, 2'b11);
      press_btn(BLap); check("lap_pause_ignored", dut_frz, 1);
      press_btn(BClr); check("clear_drops_freeze", {paused, dut_frz}, 2'b00);
    end
    // Randomized button traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      btn_ss  = 1'($urandom_range(0, 1));
      btn_clr = ($urandom_range(0, 3) == 0);
      btn_lap = LapEn ? 1'($urandom_range(0, 1)) : 1'b0;
      rst     = ($urandom_range(0, 60) == 0);
      @(negedge clk);
      rst = 1'b0;
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
